// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a time-multiplexed active-low 7-segment bus.
// Each digit is captured once per stable dwell and classified as legal, blank or illegal.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic [NUM_DIGITS-1:0]   pattern_err,
    output logic                    anode_err,
    output logic                    frame_done
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ARM = CW'(STABLE_CYCLES - 1);

    logic [6:0]              s_seg_reg, p_seg_reg;
    logic [NUM_DIGITS-1:0]   s_an_reg, p_an_reg;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [NUM_DIGITS-1:0]   mask_reg, mask_next, mask_set;
    logic [4*NUM_DIGITS-1:0] digits_reg, digits_next;
    logic [NUM_DIGITS-1:0]   valid_reg, valid_next;
    logic [NUM_DIGITS-1:0]   blank_reg, blank_next;
    logic [NUM_DIGITS-1:0]   perr_reg, perr_next;
    logic                    anode_err_reg, frame_done_reg;

    logic [NUM_DIGITS-1:0]   sel, sel_cap;
    logic                    one_hot, none_active, multi_active, same, capture, frame_hit;
    logic [3:0]              dec_value;
    logic                    dec_legal, dec_blank;

    assign sel          = ~s_an_reg;
    assign one_hot      = $onehot(sel);
    assign none_active  = (sel == '0);
    assign multi_active = !one_hot && !none_active;
    assign same         = (s_seg_reg == p_seg_reg) && (s_an_reg == p_an_reg);
    // Firing only on the STABLE-1 -> STABLE step makes a long dwell capture exactly once.
    assign capture      = one_hot && same && (cnt_reg == CNT_ARM);
    assign sel_cap      = capture ? sel : '0;

    always_comb begin
        cnt_next = '0;
        if (one_hot) begin
            if (same)
                cnt_next = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + CW'(1);
            else
                cnt_next = CW'(1);
        end
    end

    always_comb begin
        dec_value = 4'h0;
        dec_legal = 1'b1;
        dec_blank = 1'b0;
        case (s_seg_reg)
            7'b0000001: dec_value = 4'h0;
            7'b1001111: dec_value = 4'h1;
            7'b0010010: dec_value = 4'h2;
            7'b0000110: dec_value = 4'h3;
            7'b1001100: dec_value = 4'h4;
            7'b0100100: dec_value = 4'h5;
            7'b0100000: dec_value = 4'h6;
            7'b0001111: dec_value = 4'h7;
            7'b0000000: dec_value = 4'h8;
            7'b0000100: dec_value = 4'h9;
            7'b0001000: dec_value = 4'hA;
            7'b1100000: dec_value = 4'hB;
            7'b0110001: dec_value = 4'hC;
            7'b1000010: dec_value = 4'hD;
            7'b0110000: dec_value = 4'hE;
            7'b0111000: dec_value = 4'hF;
            7'b1111111: begin
                dec_legal = 1'b0;
                dec_blank = 1'b1;
            end
            default:    dec_legal = 1'b0;
        endcase
    end

    // The mask clears on the very capture that completes the frame.
    assign mask_set  = mask_reg | sel;
    assign frame_hit = capture && (&mask_set);

    always_comb begin
        mask_next = mask_reg;
        if (capture)
            mask_next = frame_hit ? '0 : mask_set;
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digits_next[4*gi +: 4] = (sel_cap[gi] && dec_legal) ? dec_value
                                                                        : digits_reg[4*gi +: 4];
            assign valid_next[gi] = sel_cap[gi] ? dec_legal : valid_reg[gi];
            assign blank_next[gi] = sel_cap[gi] ? dec_blank : blank_reg[gi];
            assign perr_next[gi]  = sel_cap[gi] ? (!dec_legal && !dec_blank) : perr_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_seg_reg      <= 7'b1111111;
            p_seg_reg      <= 7'b1111111;
            s_an_reg       <= '1;
            p_an_reg       <= '1;
            cnt_reg        <= '0;
            mask_reg       <= '0;
            digits_reg     <= '0;
            valid_reg      <= '0;
            blank_reg      <= '0;
            perr_reg       <= '0;
            anode_err_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            s_seg_reg      <= seg_n;
            s_an_reg       <= an_n;
            p_seg_reg      <= s_seg_reg;
            p_an_reg       <= s_an_reg;
            cnt_reg        <= cnt_next;
            mask_reg       <= mask_next;
            digits_reg     <= digits_next;
            valid_reg      <= valid_next;
            blank_reg      <= blank_next;
            perr_reg       <= perr_next;
            anode_err_reg  <= multi_active;
            frame_done_reg <= frame_hit;
        end
    end

    assign digits      = digits_reg;
    assign digit_valid = valid_reg;
    assign digit_blank = blank_reg;
    assign pattern_err = perr_reg;
    assign anode_err   = anode_err_reg;
    assign frame_done  = frame_done_reg;
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the hex-to-7-segment encoder.
- Samples a time-multiplexed 7-segment display bus (active-low segments plus active-low digit anodes) and recovers the hex value shown on each digit.
- Flags blank digits, illegal segment patterns and anode conflicts, and pulses once per completely captured frame.
- Sits beside the clock display driver, for self-check and loop-back verification.

Parameters:
- NUM_DIGITS, 8, number of scanned digits; range 1..16.
- STABLE_CYCLES, 4, consecutive identical samples required before a capture; range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- seg_n  input  7  segment lines, active-low; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- an_n  input  NUM_DIGITS  digit anode enables, active-low; bit k selects digit k.
- digits  output  4*NUM_DIGITS  decoded values; digit k occupies bits [4k+3:4k].
- digit_valid  output  NUM_DIGITS  bit k=1: digit k holds a value from a legal pattern.
- digit_blank  output  NUM_DIGITS  bit k=1: last capture of digit k was all segments off.
- pattern_err  output  NUM_DIGITS  bit k=1: last capture of digit k was an illegal pattern.
- anode_err  output  1  one-cycle pulse when more than one anode was active.
- frame_done  output  1  one-cycle pulse when every digit has been captured since the previous pulse.

Behaviour:
- Decode table, seg_n to value:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3
  - 1001100=4, 0100100=5, 0100000=6, 0001111=7
  - 0000000=8, 0000100=9, 0001000=A, 1100000=B
  - 0110001=C, 1000010=D, 0110000=E, 0111000=F
  - 1111111=blank.
  - Every other pattern is illegal.
- Input stage: seg_n and an_n are registered once (s_seg, s_an) on every edge. All decisions use the registered copies.
- Dwell tracking: previous sample register (p_seg, p_an) plus a stability counter cnt, width clog2(STABLE_CYCLES+1).
  - s_an has exactly one zero bit, and (s_seg, s_an) equals (p_seg, p_an): cnt increments, saturating at STABLE_CYCLES.
  - s_an has exactly one zero bit, but the sample differs from the previous one: cnt <= 1.
  - s_an is all ones (no digit active): cnt <= 0, no capture.
  - s_an has two or more zero bits: cnt <= 0, no capture, anode_err=1 on the next edge for one cycle.
- Capture fires on the cycle cnt transitions from STABLE_CYCLES-1 to STABLE_CYCLES. This gives exactly one capture per dwell; a longer dwell never re-captures.
- Capture of digit k, legal pattern: digits[k] <= value, digit_valid[k] <= 1, digit_blank[k] <= 0, pattern_err[k] <= 0.
- Capture of digit k, blank pattern: digit_blank[k] <= 1, digit_valid[k] <= 0, pattern_err[k] <= 0, digits[k] unchanged.
- Capture of digit k, illegal pattern: pattern_err[k] <= 1, digit_valid[k] <= 0, digit_blank[k] <= 0, digits[k] unchanged.
- Latency: seg_n/an_n held constant from before edge E1 cause the capture results to appear after edge E(STABLE_CYCLES+1).
- Frame tracking: a seen mask sets bit k on every capture of digit k, whatever its class.
  - When a capture makes the mask all ones: frame_done=1 for exactly one cycle, and the mask clears to 0 on the same edge.
  - A re-capture of a digit already in the mask leaves the mask unchanged.
- Reset, synchronous, with rst_n low at a rising edge:
  - Outputs: digits, digit_valid, digit_blank, pattern_err, anode_err, frame_done all go to 0.
  - Internal state: cnt=0, mask=0; s_seg and p_seg become 1111111; s_an and p_an become all ones.
  - Reset mid-dwell discards the dwell. The first edge after release starts a fresh count.
- Glitch shorter than STABLE_CYCLES samples: no output changes, but any dwell in progress restarts.

Test Plan:
- Use NUM_DIGITS=4, STABLE_CYCLES=4 for all scenarios.
- an_n=1110 with seg_n=0010010 for 4 cycles, then an_n=1101 with seg_n=0001000 for 4 cycles -> digits[3:0]=2, digits[7:4]=A, digit_valid=0011, each appearing 5 edges after its own input applied; no frame_done.
- Scan all 4 digits with 1, 2, 3, 4 at 6 cycles each -> one frame_done pulse right after the digit-3 capture, digits=16'h4321, digit_valid=1111; a second identical scan -> exactly one more pulse.
- Digit 2 shows 1111111, then 1010101 -> first digit_blank[2]=1, then pattern_err[2]=1 and digit_blank[2]=0; digits[11:8] keeps its previous value; digit_valid[2]=0 in both cases.
- an_n=1100 for 6 cycles -> one anode_err pulse per cycle that an_n was registered with both zeros (6 pulses); no captures; mask unchanged.
- Digit 1 dwell of 3 cycles, a 1-cycle pattern change, then 3 cycles of the original pattern -> no capture. Digit 0 dwell of 100 cycles -> exactly one capture.
- rst_n low for one edge at cnt=3 of a digit-0 dwell -> all outputs 0 next cycle; held input is captured only 4 samples after reset release.
